reg_bank_arbiter: RTL

- Shares one bank of NREG 8-bit load-enable registers between NREQ requesters.
- Round-robin arbitration picks one requester, then runs one read or write transaction over three cycles.
- Drives the load enables and data input of each register instance, and reads back their Q outputs.
- Sits between the requester blocks and the register bank; it is the only driver of the bank enables.

---
 rtl/reg_bank_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one register bank among NREQ requesters; one read/write per 3 cycles,
// GNT one cycle after REQ, ACK one cycle later; no backpressure, requesters simply wait while GNT is low.
module reg_bank_arbiter #(
   parameter int NREQ = 4,
   parameter int NREG = 4,
   parameter int AW   = 2,
   parameter int DW   = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ-1:0]      REQ_WE,
   input  logic [NREQ*AW-1:0]   REQ_ADDR,
   input  logic [NREQ*DW-1:0]   REQ_WDATA,
   input  logic [NREG*DW-1:0]   REG_Q,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      ACK,
   output logic [DW-1:0]        RDATA,
   output logic [NREG-1:0]      REG_ENA,
   output logic [DW-1:0]        REG_D,
   output logic                 BUSY
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]     win_q, win_d;
   logic [IW-1:0]     last_q, last_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     reg_d_q;
   logic [DW-1:0]     rdata_q, rdata_d;

   logic              arb_vld;
   logic [IW-1:0]     arb_idx;
   logic              sel_we;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic [DW-1:0]     rd_sel;

   // Search starts just after the last winner so a persistent requester drops to lowest priority.
   always_comb begin
      arb_vld = 1'b0;
      arb_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (int'(last_q) + k) % NREQ;
         if (!arb_vld && REQ[c]) begin
            arb_vld = 1'b1;
            arb_idx = IW'(c);
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_idx == IW'(i)) begin
            sel_we    = REQ_WE[i];
            sel_addr  = REQ_ADDR[i*AW +: AW];
            sel_wdata = REQ_WDATA[i*DW +: DW];
         end
      end
   end

   // Out-of-range addresses decode to nothing and read back as zero.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NREG; i++) begin
         if (addr_q == AW'(i)) rd_sel = REG_Q[i*DW +: DW];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      win_d   = win_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      REG_ENA = '0;
      ACK     = '0;
      REG_D   = reg_d_q;
      RDATA   = rdata_q;
      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               state_d = XFER;
               win_d   = arb_idx;
               we_d    = sel_we;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               gnt_d   = '0;
               gnt_d[arb_idx] = 1'b1;
            end
         end
         XFER: begin
            state_d = DONE;
            if (we_q) begin
               REG_D = wdata_q;
               for (int i = 0; i < NREG; i++) begin
                  if (addr_q == AW'(i)) REG_ENA[i] = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            ACK[win_q] = 1'b1;
            RDATA   = rd_sel;
            rdata_d = rd_sel;
            last_d  = win_q;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         win_q   <= '0;
         last_q  <= IW'(NREQ - 1);
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         reg_d_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         win_q   <= win_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         reg_d_q <= REG_D;
         rdata_q <= rdata_d;
      end
   end

   assign GNT  = gnt_q;
   assign BUSY = (state_q != IDLE);

endmodule
